afc_cal_sched: RTL

AFC_CAL_SCHED -- requirements
Module: afc_cal_sched

---
 rtl/afc_cal_sched.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/afc_cal_sched.sv
// AFC calibration scheduler: latches RX/TX calibration requests, arbitrates round-robin,
// sequences one AFC run (start pulse, wait for finish or timeout) and reports per-path results.
module afc_cal_sched #(
   parameter int unsigned EN_CYC = 10,
   parameter int unsigned TO_W   = 12
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            req_rx,
   input  logic            req_tx,
   input  logic [15:0]     divr_rx,
   input  logic [15:0]     divr_tx,
   input  logic [TO_W-1:0] rg_cal_timeout,
   input  logic            afc_finish,
   input  logic [6:0]      afc_vco_capband,
   input  logic [13:0]     afc_minerr,
   output logic            afc_en,
   output logic            trx,
   output logic [15:0]     divr,
   output logic            busy,
   output logic            done_rx,
   output logic            done_tx,
   output logic            cal_err,
   output logic [6:0]      capband_rx,
   output logic [6:0]      capband_tx,
   output logic [13:0]     minerr_rx,
   output logic [13:0]     minerr_tx
);

   localparam int unsigned EN_W = 4;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]      state, state_nx;
   logic [1:0]      pend, pend_nx;
   logic            rr_tx, rr_nx;
   logic [EN_W-1:0] en_cnt, en_cnt_nx;
   logic [TO_W-1:0] to_cnt, to_cnt_nx;
   logic            grant_tx;
   logic            trx_nx, done_rx_nx, done_tx_nx, cal_err_nx;
   logic [15:0]     divr_nx;
   logic [6:0]      capband_rx_nx, capband_tx_nx;
   logic [13:0]     minerr_rx_nx, minerr_tx_nx;

   // Next-state, arbitration and result capture
   always_comb begin
      state_nx      = state;
      pend_nx       = pend;
      rr_nx         = rr_tx;
      en_cnt_nx     = en_cnt;
      to_cnt_nx     = to_cnt;
      trx_nx        = trx;
      divr_nx       = divr;
      done_rx_nx    = 1'b0;
      done_tx_nx    = 1'b0;
      cal_err_nx    = 1'b0;
      capband_rx_nx = capband_rx;
      capband_tx_nx = capband_tx;
      minerr_rx_nx  = minerr_rx;
      minerr_tx_nx  = minerr_tx;
      // TX wins only if RX is not pending or it is TX's turn
      grant_tx      = pend[1] & (~pend[0] | rr_tx);

      case (state)
         S_IDLE: begin
            if (pend != 2'b00) begin
               state_nx  = S_START;
               trx_nx    = grant_tx;
               divr_nx   = grant_tx ? divr_tx : divr_rx;
               pend_nx   = grant_tx ? {1'b0, pend[0]} : {pend[1], 1'b0};
               rr_nx     = ~grant_tx;
               en_cnt_nx = '0;
            end
         end
         S_START: begin
            if (en_cnt == EN_W'(EN_CYC - 1)) begin
               state_nx  = S_WAIT;
               to_cnt_nx = '0;
            end else begin
               en_cnt_nx = en_cnt + EN_W'(1);
            end
         end
         S_WAIT: begin
            if (to_cnt != '1) to_cnt_nx = to_cnt + TO_W'(1);
            if (afc_finish) begin
               state_nx   = S_DONE;
               done_rx_nx = ~trx;
               done_tx_nx = trx;
               if (trx) begin
                  capband_tx_nx = afc_vco_capband;
                  minerr_tx_nx  = afc_minerr;
               end else begin
                  capband_rx_nx = afc_vco_capband;
                  minerr_rx_nx  = afc_minerr;
               end
            end else if ((rg_cal_timeout != '0) && (to_cnt == rg_cal_timeout - TO_W'(1))) begin
               state_nx   = S_DONE;
               done_rx_nx = ~trx;
               done_tx_nx = trx;
               cal_err_nx = 1'b1;
            end
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase

      // A new pulse always re-arms its path, even the one being granted
      pend_nx = pend_nx | {req_tx, req_rx};
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= S_IDLE;
         pend       <= '0;
         rr_tx      <= 1'b0;
         en_cnt     <= '0;
         to_cnt     <= '0;
         afc_en     <= 1'b0;
         trx        <= 1'b0;
         divr       <= '0;
         busy       <= 1'b0;
         done_rx    <= 1'b0;
         done_tx    <= 1'b0;
         cal_err    <= 1'b0;
         capband_rx <= '0;
         capband_tx <= '0;
         minerr_rx  <= '0;
         minerr_tx  <= '0;
      end else begin
         state      <= state_nx;
         pend       <= pend_nx;
         rr_tx      <= rr_nx;
         en_cnt     <= en_cnt_nx;
         to_cnt     <= to_cnt_nx;
         afc_en     <= (state_nx == S_START);
         trx        <= trx_nx;
         divr       <= divr_nx;
         busy       <= (state_nx != S_IDLE);
         done_rx    <= done_rx_nx;
         done_tx    <= done_tx_nx;
         cal_err    <= cal_err_nx;
         capband_rx <= capband_rx_nx;
         capband_tx <= capband_tx_nx;
         minerr_rx  <= minerr_rx_nx;
         minerr_tx  <= minerr_tx_nx;
      end
   end

endmodule
